// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host deframer with a small FWFT byte FIFO and sticky errors.
// Ports: system_clk/reset (async, active-high); PS2_clk/PS2_data raw pins;
//   rd_en pops the head, clear_errors clears flags; rd_data/rd_valid show
//   the head, fifo_count the fill level; frame_error, timeout_error and
//   overflow are sticky error flags.
module ps2_frame_receiver #(
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic             system_clk,
  input  logic             reset,
  input  logic             PS2_clk,
  input  logic             PS2_data,
  input  logic             rd_en,
  input  logic             clear_errors,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [FIFO_AW:0] fifo_count,
  output logic             frame_error,
  output logic             timeout_error,
  output logic             overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [TW-1:0]    TMO_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  logic clk_s1, clk_s2, clk_d;
  logic dat_s1, dat_s2;
  logic fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] tmo_cnt;

  logic stop_fall, push_req, ferr_set, tmo_hit;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               empty, full, pop, wr, ovf_set;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_clk;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= PS2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_d & ~clk_s2;

  // Stop-bit outcome is decided combinationally so the FIFO write
  // and the error flag land on the same edge the FSM leaves STOP.
  assign stop_fall = (state == STOP) & fall;
  assign push_req  = stop_fall & dat_s2 & par_ok;
  assign ferr_set  = stop_fall & ~(dat_s2 & par_ok);
  // A fall in the expiry cycle is genuine activity and wins.
  assign tmo_hit   = (state != IDLE) & ~fall & (tmo_cnt == TMO_MAX);

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_ok  <= 1'b0;
      tmo_cnt <= '0;
    end else if (tmo_hit) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      if (state == IDLE || fall) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE: if (!dat_s2) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{shreg, dat_s2};
            state  <= STOP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign empty = (fifo_count == '0);
  assign full  = (fifo_count == FULL_CNT);
  assign pop   = rd_en & ~empty;
  // When full, a same-cycle pop frees the slot the push needs.
  assign wr      = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign rd_valid = ~empty;
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      frame_error   <= 1'b0;
      timeout_error <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      frame_error   <= ferr_set | (frame_error & ~clear_errors);
      timeout_error <= tmo_hit | (timeout_error & ~clear_errors);
      overflow      <= ovf_set | (overflow & ~clear_errors);
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Bench for ps2_frame_receiver: directed and random PS/2 frames
// checked against a queue-based model of the byte stream and flags.
module tb_ps2_frame_receiver;

  localparam int TMO = 5000;

  logic       system_clk = 1'b0;
  logic       reset, PS2_clk, PS2_data, rd_en, clear_errors;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] fifo_count;
  logic       frame_error, timeout_error, overflow;

  ps2_frame_receiver #(
    .FIFO_AW(3), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .system_clk(system_clk), .reset(reset),
    .PS2_clk(PS2_clk), .PS2_data(PS2_data),
    .rd_en(rd_en), .clear_errors(clear_errors),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .frame_error(frame_error),
    .timeout_error(timeout_error), .overflow(overflow)
  );

  always #5 system_clk = ~system_clk;

  int n_chk = 0;
  int n_err = 0;
  int hp    = 10;

  logic [7:0] q[$];
  bit m_ferr, m_tmo, m_ovf;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [31:0] ed;
    ed = 0;
    if (q.size() != 0) ed = 32'(q[0]);
    chk({tag, ".valid"}, 32'(rd_valid), 32'(q.size() != 0));
    chk({tag, ".data"},  32'(rd_data), ed);
    chk({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, ".ferr"},  32'(frame_error), 32'(m_ferr));
    chk({tag, ".tmo"},   32'(timeout_error), 32'(m_tmo));
    chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge system_clk);
  endtask

  // One PS/2 bit: data set while clock high, then a low half-period.
  // pop_here raises rd_en so it is seen on the edge the fall acts on.
  task automatic ps2_bit(input bit b, input bit pop_here);
    PS2_data = b;
    cyc(hp);
    PS2_clk = 1'b0;
    for (int i = 0; i < hp; i++) begin
      @(negedge system_clk);
      if (pop_here && i == 1) rd_en = 1'b1;
      if (pop_here && i == 2) rd_en = 1'b0;
    end
    PS2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par,
                            input bit stop_b, input bit pop_stop);
    bit p;
    p = ~(^d) ^ bad_par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
    ps2_bit(p, 1'b0);
    ps2_bit(stop_b, pop_stop);
    PS2_data = 1'b1;
    cyc(4);
    if (pop_stop && q.size() > 0) void'(q.pop_front());
    if (!bad_par && stop_b) begin
      if (q.size() < 8) q.push_back(d);
      else              m_ovf = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic partial(input logic [7:0] d, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(d[i], 1'b0);
    PS2_data = 1'b1;
  endtask

  task automatic pop_chk(input string tag);
    chk_all({tag, ".pre"});
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    cyc(1);
    chk_all({tag, ".post"});
  endtask

  task automatic clr();
    clear_errors = 1'b1;
    cyc(1);
    clear_errors = 1'b0;
    m_ferr = 0;
    m_tmo  = 0;
    m_ovf  = 0;
    cyc(1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int k;
    reset = 1'b1; PS2_clk = 1'b1; PS2_data = 1'b1;
    rd_en = 1'b0; clear_errors = 1'b0;
    cyc(3);
    chk_all("reset");
    reset = 1'b0;
    cyc(3);

    send_frame(8'h1C, 0, 1, 0);
    chk_all("good1c");
    pop_chk("pop1c");

    send_frame(8'h1C, 1, 1, 0);
    chk_all("badpar");
    send_frame(8'hF0, 0, 1, 0);
    chk_all("goodf0");
    pop_chk("popf0");
    clr();
    chk_all("clr1");

    send_frame(8'h1C, 0, 0, 0);
    chk_all("badstop");
    clr();

    for (int v = 1; v <= 9; v++) send_frame(8'(v), 0, 1, 0);
    chk_all("full");
    clr();
    chk_all("fullclr");
    send_frame(8'h0A, 0, 1, 1);
    chk_all("fullpp");
    while (q.size() > 0) pop_chk("drain");
    pop_chk("popempty");

    partial(8'h00, 4);
    cyc(TMO + 20);
    m_tmo = 1'b1;
    chk_all("tmo");
    send_frame(8'h5A, 0, 1, 0);
    chk_all("after_tmo");
    pop_chk("pop5a");
    clr();

    send_frame(8'h33, 0, 1, 0);
    partial(8'hA5, 5);
    cyc(2);
    reset = 1'b1;
    q.delete();
    m_ferr = 0; m_tmo = 0; m_ovf = 0;
    cyc(2);
    chk_all("midrst");
    reset = 1'b0;
    cyc(3);
    send_frame(8'h29, 0, 1, 0);
    chk_all("after_rst");

    for (int n = 0; n < 40; n++) begin
      hp = $urandom_range(4, 12);
      k  = $urandom_range(0, 9);
      d  = 8'($urandom);
      case (k)
        6:       send_frame(d, 1, 1, 0);
        7:       send_frame(d, 0, 0, 0);
        8:       pop_chk("rnd_pop");
        9: begin
          ps2_bit(1'b1, 1'b0);
          clr();
        end
        default: send_frame(d, 0, 1, $urandom_range(0, 3) == 0);
      endcase
      chk_all("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
